// File: rtl/n64_sched_pkg.sv
// Shared types and constants for the N64 poll scheduler: FSM states,
// register offsets, bit positions and the port-search helper.
package n64_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GUARD
  } state_e;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_PERIOD = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_DATA0  = 8'h10;

  localparam logic [7:0] N64_CMD_STATUS = 8'h01;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MASK_LSB  = 8;
  localparam int CTRL_IRQEN_BIT = 16;

  localparam int STAT_VALID_LSB   = 0;
  localparam int STAT_NORESP_LSB  = 4;
  localparam int STAT_HANG_BIT    = 8;
  localparam int STAT_OVERRUN_BIT = 9;
  localparam int STAT_BUSY_BIT    = 16;
  localparam int STAT_IRQ_BIT     = 31;

  // Lowest set bit of mask at index >= from; returns {found, index}.
  function automatic logic [2:0] find_port(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/n64_sched_regs.sv
// APB register file for the poll scheduler: CTRL/PERIOD/STATUS/DATA_i,
// W1C sticky status with hardware-set priority, registered read data.
// Optional frame-change interrupt is built when N64_SCHED_IRQ_EN is defined.
module n64_sched_regs
  import n64_sched_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic        pclk_i,
  input  logic        presern_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [7:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  input  logic        cap_valid_i,
  input  logic        cap_noresp_i,
  input  logic [1:0]  cap_port_i,
  input  logic [31:0] cap_data_i,
  input  logic        hang_set_i,
  input  logic        overrun_set_i,
  input  logic        frame_start_i,
  input  logic        frame_end_i,
  input  logic        busy_i,
  output logic        enable_o,
  output logic [3:0]  mask_o,
  output logic [31:0] period_o,
  output logic        period_wr_o,
  output logic        irq_o
);

  logic                 wr_en, rd_setup, ctrl_wr, status_wr;
  logic                 enable_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [31:0]          period_q;
  logic [NUM_PORTS-1:0] valid_q, valid_d, noresp_q, noresp_d, port_hit;
  logic                 hang_q, hang_d, overrun_q, overrun_d;
  logic [31:0]          data_q [NUM_PORTS];
  logic [31:0]          prdata_q, rdata;
  logic                 unused_pwdata;

  assign wr_en       = psel_i & penable_i & pwrite_i;
  assign rd_setup    = psel_i & ~penable_i & ~pwrite_i;
  assign ctrl_wr     = wr_en && (paddr_i == REG_CTRL);
  assign status_wr   = wr_en && (paddr_i == REG_STATUS);
  assign period_wr_o = wr_en && (paddr_i == REG_PERIOD);
  assign enable_o    = enable_q;
  assign period_o    = period_q;
  assign prdata_o    = prdata_q;
  assign unused_pwdata = ^pwdata_i;

  // Decode which port the current capture event belongs to; pad the mask.
  always_comb begin
    mask_o = '0;
    mask_o[NUM_PORTS-1:0] = mask_q;
    for (int i = 0; i < NUM_PORTS; i++) port_hit[i] = (cap_port_i == 2'(i));
  end

  // Sticky status next state: W1C clears first, hardware sets override.
  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational block, so no path can infer a latch.
    valid_d   = valid_q;
    noresp_d  = noresp_q;
    hang_d    = hang_q;
    overrun_d = overrun_q;
    if (status_wr) begin
      valid_d   = valid_q  & ~pwdata_i[STAT_VALID_LSB  +: NUM_PORTS];
      noresp_d  = noresp_q & ~pwdata_i[STAT_NORESP_LSB +: NUM_PORTS];
      hang_d    = hang_q    & ~pwdata_i[STAT_HANG_BIT];
      overrun_d = overrun_q & ~pwdata_i[STAT_OVERRUN_BIT];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cap_valid_i  && port_hit[i]) valid_d[i]  = 1'b1;
      if (cap_noresp_i && port_hit[i]) noresp_d[i] = 1'b1;
    end
    if (hang_set_i)    hang_d    = 1'b1;
    if (overrun_set_i) overrun_d = 1'b1;
  end

`ifdef N64_SCHED_IRQ_EN
  logic irq_en_q, changed_q, changed_d, irq_q, irq_d;

  // Track data changes within a frame and raise a level irq at frame end.
  always_comb begin
    changed_d = frame_start_i ? 1'b0 : changed_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cap_valid_i && port_hit[i] && (cap_data_i != data_q[i])) changed_d = 1'b1;
    end
    irq_d = irq_q & ~(status_wr & pwdata_i[STAT_IRQ_BIT]);
    if (frame_end_i && irq_en_q && changed_q) irq_d = 1'b1;
  end

  // Interrupt enable, change flag and pending state.
  always_ff @(posedge pclk_i) begin
    if (presern_i) begin
      irq_en_q  <= 1'b0;
      changed_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= pwdata_i[CTRL_IRQEN_BIT];
      changed_q <= changed_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{frame_start_i, frame_end_i};
  assign irq_o = 1'b0;
`endif

  // Read mux for the registered APB read data.
  always_comb begin
    rdata = '0;
    case (paddr_i)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT] = enable_q;
        rdata[CTRL_MASK_LSB +: NUM_PORTS] = mask_q;
`ifdef N64_SCHED_IRQ_EN
        rdata[CTRL_IRQEN_BIT] = irq_en_q;
`endif
      end
      REG_PERIOD: rdata = period_q;
      REG_STATUS: begin
        rdata[STAT_VALID_LSB  +: NUM_PORTS] = valid_q;
        rdata[STAT_NORESP_LSB +: NUM_PORTS] = noresp_q;
        rdata[STAT_HANG_BIT]    = hang_q;
        rdata[STAT_OVERRUN_BIT] = overrun_q;
        rdata[STAT_BUSY_BIT]    = busy_i;
`ifdef N64_SCHED_IRQ_EN
        rdata[STAT_IRQ_BIT]     = irq_q;
`endif
      end
      default: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (paddr_i == REG_DATA0 + 8'(4 * i)) rdata = data_q[i];
        end
      end
    endcase
  end

  // Register file, captured replies and setup-phase read data.
  always_ff @(posedge pclk_i) begin
    if (presern_i) begin
      enable_q  <= 1'b0;
      mask_q    <= '0;
      period_q  <= '0;
      valid_q   <= '0;
      noresp_q  <= '0;
      hang_q    <= 1'b0;
      overrun_q <= 1'b0;
      prdata_q  <= '0;
      // NOTE: the reply array is software-visible and must read 0 after reset, so it is cleared here rather than left as uninitialised storage.
      for (int i = 0; i < NUM_PORTS; i++) data_q[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= pwdata_i[CTRL_EN_BIT];
        mask_q   <= pwdata_i[CTRL_MASK_LSB +: NUM_PORTS];
      end
      if (period_wr_o) period_q <= pwdata_i;
      valid_q   <= valid_d;
      noresp_q  <= noresp_d;
      hang_q    <= hang_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cap_valid_i && port_hit[i]) data_q[i] <= cap_data_i;
      end
      if (rd_setup) prdata_q <= rdata;
    end
  end

endmodule

// File: rtl/n64_poll_scheduler.sv
// N64 status-poll scheduler: period counter, per-frame port sequencing FSM,
// guard spacing and watchdog around a shared single-wire bit engine.
// Optional frame-change interrupt: define N64_SCHED_IRQ_EN.
module n64_poll_scheduler
  import n64_sched_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int GUARD_CYCLES = 200,
  parameter int WDOG_CYCLES  = 20000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        eng_start,
  output logic [7:0]  eng_cmd,
  output logic [1:0]  eng_port,
  output logic        eng_abort,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [31:0] eng_data,
  input  logic        eng_noresp,
  output logic        irq
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  state_e          state_q, state_d;
  logic [1:0]      port_q, port_d;
  logic [3:0]      fmask_q, fmask_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            start_q, start_d, abort_q, abort_d;
  logic            enable, period_wr, tick, frame_active;
  logic            cap_valid, cap_noresp, hang_set, frame_start, frame_end;
  logic [3:0]      mask;
  logic [31:0]     period;
  logic [2:0]      first, nxt;
  logic            unused_paddr;

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign eng_cmd   = N64_CMD_STATUS;
  assign eng_start = start_q;
  assign eng_abort = abort_q;
  assign eng_port  = port_q;
  assign unused_paddr = ^PADDR[31:8];

  assign frame_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE) || (state_q == ST_GUARD);
  assign tick  = enable && ((period == 32'd0) || (cnt_q == period - 32'd1));
  assign first = find_port(mask, 3'd0);
  assign nxt   = find_port(fmask_q, {1'b0, port_q} + 3'd1);

  n64_sched_regs #(.NUM_PORTS(NUM_PORTS)) u_regs (
    .pclk_i        (PCLK),
    .presern_i     (PRESERN),
    .psel_i        (PSEL),
    .penable_i     (PENABLE),
    .pwrite_i      (PWRITE),
    .paddr_i       (PADDR[7:0]),
    .pwdata_i      (PWDATA),
    .prdata_o      (PRDATA),
    .cap_valid_i   (cap_valid),
    .cap_noresp_i  (cap_noresp),
    .cap_port_i    (port_q),
    .cap_data_i    (eng_data),
    .hang_set_i    (hang_set),
    .overrun_set_i (tick && frame_active),
    .frame_start_i (frame_start),
    .frame_end_i   (frame_end),
    .busy_i        (frame_active),
    .enable_o      (enable),
    .mask_o        (mask),
    .period_o      (period),
    .period_wr_o   (period_wr),
    .irq_o         (irq)
  );

  // Free-running frame counter; a PERIOD write restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (period_wr)   cnt_d = '0;
    else if (enable) cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
  end

  // Scheduler next-state and one-cycle engine strobes.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    fmask_d     = fmask_q;
    gcnt_d      = gcnt_q;
    wdog_d      = wdog_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    cap_valid   = 1'b0;
    cap_noresp  = 1'b0;
    hang_set    = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick && (mask != 4'd0)) begin
          fmask_d     = mask;
          port_d      = first[1:0];
          frame_start = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!enable) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end else if (!eng_busy) begin
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        wdog_d = wdog_q + 1'b1;
        gcnt_d = '0;
        if (eng_done) begin
          cap_valid = 1'b1;
          state_d   = ST_GUARD;
        end else if (eng_noresp) begin
          cap_noresp = 1'b1;
          state_d    = ST_GUARD;
        end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
          abort_d  = 1'b1;
          hang_set = 1'b1;
          state_d  = ST_GUARD;
        end
      end
      ST_GUARD: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
          if (!enable) begin
            frame_end = 1'b1;
            state_d   = ST_IDLE;
          end else if (nxt[2]) begin
            port_d  = nxt[1:0];
            state_d = ST_ISSUE;
          end else begin
            frame_end = 1'b1;
            state_d   = ST_WAIT_TICK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered engine outputs.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      fmask_q <= '0;
      gcnt_q  <= '0;
      wdog_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      port_q  <= port_d;
      fmask_q <= fmask_d;
      gcnt_q  <= gcnt_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Directed bench for n64_poll_scheduler with a behavioural engine and a
// scoreboard of expected eng_start ports.
module tb_n64_poll_scheduler;
  import n64_sched_pkg::*;

  localparam int G = 20;
  localparam int W = 300;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        eng_start, eng_abort;
  logic [7:0]  eng_cmd;
  logic [1:0]  eng_port;
  logic        eng_busy = 1'b0, eng_done = 1'b0, eng_noresp = 1'b0;
  logic [31:0] eng_data = '0;
  logic        irq;

  int          vectors = 0;
  int          miscompares = 0;
  int          aborts = 0;
  int          cyc = 0;
  int          exp_q[$];

  n64_poll_scheduler #(.NUM_PORTS(4), .GUARD_CYCLES(G), .WDOG_CYCLES(W)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_port(eng_port), .eng_abort(eng_abort),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_data(eng_data), .eng_noresp(eng_noresp),
    .irq(irq)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every eng_start must match the next expected port.
  always @(negedge PCLK) begin
    if (eng_abort) aborts++;
    if (eng_start) begin
      if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
      else check("start_port", 32'(eng_port), 32'(exp_q.pop_front()));
    end
  end

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'd0, addr}; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'd0, addr};
    @(negedge PCLK);
    PENABLE = 1'b1;
    data = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic wait_start(input string tag, input int budget, output int t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (eng_start) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Engine model: busy for lat cycles, then a done or noresp pulse.
  task automatic respond(input logic is_done, input logic [31:0] data, input int lat, output int t);
    eng_busy = 1'b1;
    repeat (lat) @(negedge PCLK);
    if (is_done) begin
      eng_done = 1'b1;
      eng_data = data;
    end else begin
      eng_noresp = 1'b1;
    end
    t = cyc;
    @(negedge PCLK);
    eng_done = 1'b0;
    eng_noresp = 1'b0;
    eng_busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ts, td, ta;
    logic seen;

    // Reset state
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b0;
    @(negedge PCLK);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_abort", 32'(eng_abort), 32'd0);
    check("rst_port", 32'(eng_port), 32'd0);
    check("rst_cmd", 32'(eng_cmd), 32'h01);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("pready", 32'(PREADY), 32'd1);
    check("pslverr", 32'(PSLVERR), 32'd0);
    read_check("rst_status", REG_STATUS, 32'd0);

    // Frame with mask 0b0101: ports 0 then 2, guard spacing
    apb_write(REG_PERIOD, 32'd3000);
    apb_write(REG_CTRL, 32'h0000_0501);
    read_check("ctrl_rb", REG_CTRL, 32'h0000_0501);
    read_check("period_rb", REG_PERIOD, 32'd3000);
    exp_q.push_back(0); exp_q.push_back(2);
    wait_start("start_p0", 4000, ts);
    respond(1'b1, 32'h8000_0000, 10, td);
    wait_start("start_p2", 100, ts);
    check("guard_spacing", 32'(ts - td), 32'(G + 2));
    respond(1'b1, 32'h1234_5678, 7, td);
    repeat (G + 10) @(negedge PCLK);
    read_check("data0", REG_DATA0, 32'h8000_0000);
    read_check("data2", REG_DATA0 + 8'h08, 32'h1234_5678);
    read_check("status_valid", REG_STATUS, 32'h0000_0005);
    read_check("unmapped", 8'h0C, 32'd0);

    // Port 1 no-response, then W1C of noresp[1]
    apb_write(REG_CTRL, 32'h0000_0201);
    exp_q.push_back(1);
    wait_start("start_p1_nr", 4000, ts);
    respond(1'b0, 32'hDEAD_BEEF, 12, td);
    repeat (G + 10) @(negedge PCLK);
    read_check("status_noresp", REG_STATUS, 32'h0000_0025);
    read_check("data1_unchanged", REG_DATA0 + 8'h04, 32'd0);
    apb_write(REG_STATUS, 32'h0000_0020);
    read_check("status_w1c", REG_STATUS, 32'h0000_0005);

    // Hung engine: watchdog abort, then continue with port 2
    apb_write(REG_CTRL, 32'h0000_0601);
    exp_q.push_back(1); exp_q.push_back(2);
    wait_start("start_p1_hang", 4000, ts);
    eng_busy = 1'b1;
    seen = 1'b0;
    ta = 0;
    for (int i = 0; i < W + 50; i++) begin
      @(negedge PCLK);
      if (eng_abort) begin
        seen = 1'b1;
        ta = cyc;
        break;
      end
    end
    check("abort_seen", 32'(seen), 32'd1);
    check("wdog_latency", 32'(ta - ts), 32'(W));
    eng_busy = 1'b0;
    wait_start("start_p2_after_hang", 100, ts);
    respond(1'b1, 32'hCAFE_0002, 5, td);
    repeat (G + 10) @(negedge PCLK);
    read_check("status_hang", REG_STATUS, 32'h0000_0105);

    // Short period, 4 ports: overrun; clear enable during the last transaction
    apb_write(REG_PERIOD, 32'd100);
    apb_write(REG_CTRL, 32'h0000_0F01);
    for (int p = 0; p < 4; p++) exp_q.push_back(p);
    for (int p = 0; p < 3; p++) begin
      wait_start("start_ovr", 300, ts);
      respond(1'b1, 32'h100 + 32'(p), 10, td);
    end
    wait_start("start_ovr_last", 300, ts);
    eng_busy = 1'b1;
    apb_write(REG_CTRL, 32'h0000_0F00);
    respond(1'b1, 32'h0000_0103, 5, td);
    repeat (300) @(negedge PCLK);
    read_check("status_overrun", REG_STATUS, 32'h0000_030F);
    read_check("data2_new", REG_DATA0 + 8'h08, 32'h0000_0102);
    read_check("data3", REG_DATA0 + 8'h0C, 32'h0000_0103);
    check("abort_count", 32'(aborts), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-WAIT_DONE on port 2
    apb_write(REG_PERIOD, 32'd200);
    apb_write(REG_CTRL, 32'h0000_0401);
    exp_q.push_back(2);
    wait_start("start_p2_rst", 400, ts);
    eng_busy = 1'b1;
    repeat (5) @(negedge PCLK);
    check("pre_rst_port", 32'(eng_port), 32'd2);
    PRESERN = 1'b1;
    @(negedge PCLK);
    PRESERN = 1'b0;
    check("mid_rst_port", 32'(eng_port), 32'd0);
    check("mid_rst_start", 32'(eng_start), 32'd0);
    check("mid_rst_abort", 32'(eng_abort), 32'd0);
    check("mid_rst_prdata", PRDATA, 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    eng_busy = 1'b0;
    read_check("mid_rst_ctrl", REG_CTRL, 32'd0);
    read_check("mid_rst_data0", REG_DATA0, 32'd0);
    read_check("mid_rst_status", REG_STATUS, 32'd0);
    repeat (300) @(negedge PCLK);
    check("rst_no_abort", 32'(aborts), 32'd1);

`ifdef N64_SCHED_IRQ_EN
    // Frame-change interrupt
    apb_write(REG_PERIOD, 32'd500);
    apb_write(REG_CTRL, 32'h0001_0101);
    read_check("ctrl_irqen_rb", REG_CTRL, 32'h0001_0101);
    exp_q.push_back(0);
    wait_start("start_irq1", 700, ts);
    respond(1'b1, 32'h0000_1111, 6, td);
    repeat (G + 5) @(negedge PCLK);
    check("irq_on_change", 32'(irq), 32'd1);
    read_check("status_irq", REG_STATUS, 32'h8000_0001);
    apb_write(REG_STATUS, 32'h8000_0000);
    check("irq_cleared", 32'(irq), 32'd0);
    exp_q.push_back(0);
    wait_start("start_irq2", 700, ts);
    respond(1'b1, 32'h0000_1111, 6, td);
    repeat (G + 5) @(negedge PCLK);
    check("irq_same_data", 32'(irq), 32'd0);
    apb_write(REG_CTRL, 32'd0);
    repeat (G + 40) @(negedge PCLK);
`else
    apb_write(REG_CTRL, 32'h0001_0000);
    read_check("ctrl_irqen_absent", REG_CTRL, 32'd0);
    check("irq_tied", 32'(irq), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/n64_poll_scheduler.md
# n64_poll_scheduler

Sequences periodic N64 status polls across up to `NUM_PORTS` controller lines sharing one single-wire bit engine. It is an APB3 slave on the fabric bus: firmware sets the poll period and port mask, and the block issues one `0x01` status command per enabled port per frame. It captures each 32-bit reply into per-port registers and flags missing or hung transactions.

## Interface
Parameters:
- `NUM_PORTS`, 4: controller ports served, 1–4.
- `GUARD_CYCLES`, 200: idle PCLK cycles between transactions (2 µs at 100 MHz).
- `WDOG_CYCLES`, 20000: maximum cycles in WAIT_DONE before the scheduler aborts.

Ports:
- `PCLK`, in, 1: the only clock, 100 MHz.
- `PRESERN`, in, 1: reset, synchronous, active-high.
- `PSEL`, `PENABLE`, `PWRITE`, in, 1 each: APB3 control.
- `PADDR`, in, 32: APB address; only `[7:0]` is decoded.
- `PWDATA`, in, 32: APB write data.
- `PRDATA`, out, 32: APB read data.
- `PREADY`, out, 1: tied 1.
- `PSLVERR`, out, 1: tied 0.
- `eng_start`, out, 1: one-cycle pulse that starts a transaction.
- `eng_cmd`, out, 8: command byte, always `0x01`.
- `eng_port`, out, 2: selected line, held for the whole transaction.
- `eng_abort`, out, 1: one-cycle pulse that forces the engine idle.
- `eng_busy`, in, 1: engine active.
- `eng_done`, in, 1: one-cycle pulse; `eng_data` valid this cycle.
- `eng_data`, in, 32: received button/stick word.
- `eng_noresp`, in, 1: one-cycle pulse, ends the transaction with no reply.
- `irq`, out, 1: frame-change interrupt (see Configuration).

## Operation
Registers, read/write unless noted:
- `0x00 CTRL`:
  - [0] enable.
  - [11:8] port mask; bits at or above `NUM_PORTS` read 0.
  - [16] irq_en.
- `0x04 PERIOD`: frame period in PCLK cycles. Value 0 runs frames back to back.
- `0x08 STATUS`:
  - [3:0] valid, sticky.
  - [7:4] noresp, sticky.
  - [8] hang, sticky.
  - [9] overrun, sticky.
  - [16] busy, read-only.
  - Sticky bits are cleared by writing 1 (W1C). If a hardware set and a W1C hit the same cycle, set wins.
- `0x10 + 4*i DATA_i`: last good reply of port i, read-only. Unmapped offsets read 0 and ignore writes.

APB:
- Writes take effect in the access phase (`PSEL & PENABLE & PWRITE`).
- `PRDATA` is registered in the setup phase (`PSEL & !PENABLE & !PWRITE`) and held through the access phase.

Period counter:
- 32-bit up-counter, runs only while enabled.
- At `PERIOD-1` it wraps to 0 and raises `tick`.
- Writing PERIOD clears the counter.

FSM states: IDLE, WAIT_TICK, ISSUE, WAIT_DONE, GUARD.
- IDLE → WAIT_TICK when enable=1.
- WAIT_TICK → ISSUE on `tick` when mask≠0. A frame latches the mask and starts at the lowest set port.
- ISSUE: drive `eng_start` for one cycle with `eng_port`=current port → WAIT_DONE. ISSUE is entered only when `eng_busy`=0; otherwise it waits.
- WAIT_DONE:
  - On `eng_done`: DATA_i ← `eng_data`, valid[i] ← 1, → GUARD.
  - On `eng_noresp`: noresp[i] ← 1, DATA_i unchanged, → GUARD.
  - If the watchdog reaches `WDOG_CYCLES`: pulse `eng_abort`, set hang, → GUARD.
- GUARD: wait `GUARD_CYCLES`. Then go to the next set port in the latched mask (ISSUE). After the last port, go to WAIT_TICK, or IDLE if enable=0.

Boundary rules:
- Clearing enable mid-frame lets the in-flight transaction finish, then → IDLE. No abort is issued.
- A mask write mid-frame applies from the next frame.
- A `tick` arriving while a frame is active sets overrun and is dropped.
- `done` and `noresp` in the same cycle: done wins.
- Reset mid-transaction returns to IDLE with no abort. The engine is reset by the same `PRESERN`.

## Timing
Reset values:
- All registers 0, `PRDATA`=0.
- `eng_start`=`eng_abort`=0, `eng_port`=0, `eng_cmd`=`0x01`, `irq`=0.

Latencies:
- `eng_start` asserts one cycle after entering ISSUE.
- DATA_i and valid[i] update one cycle after `eng_done`. A same-cycle APB read returns the old value.
- Spacing from one `eng_done` to the next `eng_start` is exactly `GUARD_CYCLES+2` cycles.
- The watchdog counts from the cycle after `eng_start`.

## Configuration
- `N64_SCHED_IRQ_EN` defined:
  - At frame end, `irq` asserts if irq_en=1 and any DATA_i changed during the frame.
  - `irq` is level, held until STATUS is written with bit 31 set. Bit 31 reads as the irq pending state.
- Not defined: `irq` is tied 0, CTRL[16] reads 0, and no change-tracking logic is built.

## Structure
- Package `n64_sched_pkg` holds:
  - the FSM state enum;
  - register offsets;
  - the `N64_CMD_STATUS` = `8'h01` constant;
  - STATUS bit positions.
- Sub-module `n64_sched_regs` implements the APB decode, register file and W1C logic. The FSM and counters stay in the top level.

## Test plan
- Setup: PERIOD=1600000, mask=0b0101, enable. → Exactly two `eng_start` pulses per frame, on ports 0 then 2. Then return `eng_done` with `0x80000000` → DATA_0=`0x80000000`, valid[0]=1.
- Port 1 answers with an `eng_noresp` pulse. → noresp[1]=1 and DATA_1 unchanged. Then write STATUS=`0x20` → noresp[1]=0.
- Hold `eng_busy` high and never pulse done. → `eng_abort` fires exactly `WDOG_CYCLES` after the start, hang=1, and the scheduler proceeds to the next port.
- Set PERIOD=100 with 4 ports enabled. → overrun=1 and no `eng_start` while a frame is active.
- Clear enable mid-transaction. → The transaction completes, the FSM reaches IDLE, and no further `eng_start` pulses occur. Assert `PRESERN` for 1 cycle mid-WAIT_DONE → all outputs return to their reset values on the next edge.
- With `N64_SCHED_IRQ_EN` and irq_en=1: a data change during a frame raises `irq` at frame end; identical data leaves `irq` at 0.
